// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : Pops bytes from a registered-read TX FIFO and frames them onto a
//            UART line (start, 8 data LSB-first, optional parity, stop bits).
//            Define UART_TX_PARITY_EN to insert the parity bit.
// Revision : 1.0
// ============================================================================
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FETCH_END = CNT_W'(1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 ||
        !(STOP_BITS == 1 || STOP_BITS == 2) ||
        !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_bad_params
        $error("uart_tx_serializer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nx;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_nx;
    logic             w_tx_nx;
    logic             w_rd_nx;
    logic             w_busy_nx;
    logic             w_done_nx;
`ifdef UART_TX_PARITY_EN
    localparam logic  C_ODD = (PARITY_ODD != 0);
    logic             r_parity;
    logic             w_parity_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shreg    <= '0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_shreg    <= w_shreg_nx;
            tx         <= w_tx_nx;
            fifo_rd_en <= w_rd_nx;
            tx_busy    <= w_busy_nx;
            tx_done    <= w_done_nx;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nx;
        end
    end
`endif

    // Next-state decode; the line outputs are then registered from the
    // *next* state so every output lines up with the state it belongs to.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_idx_nx    = r_idx;
        w_shreg_nx  = r_shreg;
        w_rd_nx     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nx = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                w_idx_nx = '0;
                if (!fifo_empty) begin
                    w_state_nx = S_FETCH;
                    w_rd_nx    = 1'b1;
                end
            end
            S_FETCH: begin
                if (r_cnt == FETCH_END) begin
                    w_state_nx  = S_START;
                    w_cnt_nx    = '0;
                    w_shreg_nx  = fifo_data;
`ifdef UART_TX_PARITY_EN
                    w_parity_nx = (^fifo_data) ^ C_ODD;
`endif
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_START: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = S_DATA;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx = '0;
                    if (r_idx == 3'd7) begin
                        w_idx_nx   = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = S_STOP;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx = '0;
                    if (r_idx == STOP_LAST) begin
                        w_state_nx = S_IDLE;
                        w_idx_nx   = '0;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_idx_nx   = '0;
            end
        endcase
    end

    always_comb begin
        w_tx_nx = 1'b1;
        case (w_state_nx)
            S_START:  w_tx_nx = 1'b0;
            S_DATA:   w_tx_nx = w_shreg_nx[w_idx_nx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nx = w_parity_nx;
`endif
            default:  w_tx_nx = 1'b1;
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
        w_done_nx = (w_state_nx == S_STOP) && (w_cnt_nx == CNT_LAST) &&
                    (w_idx_nx == STOP_LAST);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// Bench for uart_tx_serializer: two instances (1 and 2 stop bits, even/odd
// parity) fed by queue-based FIFO models, checked against a bit-level frame model.
module tb_uart_tx_serializer;

    localparam int CPB = 16;
    localparam int STOP0 = 1;
    localparam int STOP1 = 2;
    localparam int ODD0 = 0;
    localparam int ODD1 = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       fifo_empty [2];
    logic [7:0] fifo_data  [2];
    logic       fifo_rd_en [2];
    logic       tx         [2];
    logic       tx_busy    [2];
    logic       tx_done    [2];
    logic       emp_q      [2];
    logic       glitch     [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         pops [2];
    int         cyc;
    int         vectors;
    int         miscompares;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOP0), .PARITY_ODD(ODD0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
        .fifo_rd_en(fifo_rd_en[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOP1), .PARITY_ODD(ODD1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
        .fifo_rd_en(fifo_rd_en[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty[0] = emp_q[0] & ~glitch[0];
    assign fifo_empty[1] = emp_q[1] & ~glitch[1];

    // FIFO models with one-clock registered read data.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en[0] === 1'b1 && q0.size() != 0) fifo_data[0] <= q0.pop_front();
        if (fifo_rd_en[1] === 1'b1 && q1.size() != 0) fifo_data[1] <= q1.pop_front();
    end

    always @(negedge clk) begin
        emp_q[0] = (q0.size() == 0);
        emp_q[1] = (q1.size() == 0);
        if (fifo_rd_en[0] === 1'b1) pops[0] = pops[0] + 1;
        if (fifo_rd_en[1] === 1'b1) pops[1] = pops[1] + 1;
    end

    function automatic int stop_bits(input int d);
        return (d == 0) ? STOP0 : STOP1;
    endfunction

    function automatic int frame_len(input int d);
        return (1 + 8 + PB + stop_bits(d)) * CPB;
    endfunction

    // Expected line level k clocks after the first start-bit clock.
    function automatic logic exp_tx(input int d, input logic [7:0] b, input int k);
        int pos;
        pos = k / CPB;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return (^b) ^ ((d == 0) ? (ODD0 != 0) : (ODD1 != 0));
`endif
        return 1'b1;
    endfunction

    task automatic push(input int d, input logic [7:0] b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic check_frame(input int d, input logic [7:0] b, output int t_start, output int t_end);
        int n, fl, bad_k, done_cnt, done_k;
        logic got, busy_ok;
        logic [7:0] dec;
        fl = frame_len(d);
        n  = 0;
        @(negedge clk);
        while (tx[d] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (tx[d] !== 1'b0) begin
            $display("FAIL start_timeout dut%0d: tx=%b, required 0 within 3000 clocks", d, tx[d]);
            miscompares++;
            t_start = cyc;
            t_end   = cyc;
            return;
        end
        t_start = cyc; bad_k = -1; got = 1'b0; done_cnt = 0; done_k = -1; busy_ok = 1'b1; dec = '0;
        for (int k = 0; k < fl; k++) begin
            if (k > 0) @(negedge clk);
            if (tx[d] !== exp_tx(d, b, k) && bad_k < 0) begin
                bad_k = k;
                got   = tx[d];
            end
            if (tx_done[d] === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (tx_busy[d] !== 1'b1) busy_ok = 1'b0;
            if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) dec[k/CPB-1] = tx[d];
        end
        t_end = cyc;
        vectors++;
        if (bad_k >= 0) begin
            $display("FAIL frame_tx dut%0d byte %h clock %0d: tx=%b, required %b", d, b, bad_k, got, exp_tx(d, b, bad_k));
            miscompares++;
        end
        vectors++;
        if (dec !== b) begin
            $display("FAIL decoded_byte dut%0d: got %h, required %h", d, dec, b);
            miscompares++;
        end
        vectors++;
        if (done_cnt != 1 || done_k != fl - 1) begin
            $display("FAIL tx_done_pos dut%0d: %0d pulses last at clock %0d, required 1 at clock %0d", d, done_cnt, done_k, fl - 1);
            miscompares++;
        end
        vectors++;
        if (!busy_ok) begin
            $display("FAIL tx_busy_frame dut%0d: busy dropped during frame, required 1", d);
            miscompares++;
        end
    endtask

    task automatic check_pops(input string name, input int d, input int expected);
        vectors++;
        if (pops[d] != expected) begin
            $display("FAIL %s dut%0d: pops=%0d, required %0d", name, d, pops[d], expected);
            miscompares++;
        end
    endtask

    task automatic check_idle(input string name, input int d);
        vectors++;
        if ({tx[d], fifo_rd_en[d], tx_busy[d], tx_done[d]} !== 4'b1000) begin
            $display("FAIL %s dut%0d: tx/rd/busy/done=%b%b%b%b, required 1000", name, d,
                     tx[d], fifo_rd_en[d], tx_busy[d], tx_done[d]);
            miscompares++;
        end
    endtask

    task automatic test_reset;
        logic quiet;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_idle("reset_outputs", 0);
            check_idle("reset_outputs", 1);
        end
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || tx[1] !== 1'b1 || tx_busy[0] !== 1'b0 || tx_busy[1] !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            $display("FAIL idle_line: line or busy moved with empty FIFO, required tx=1 busy=0");
            miscompares++;
        end
        check_pops("idle_no_pop", 0, 0);
        check_pops("idle_no_pop", 1, 0);
    endtask

    task automatic test_single_byte;
        int p0, ts, te;
        p0 = pops[0];
        push(0, 8'h55);
        check_frame(0, 8'h55, ts, te);
        @(negedge clk);
        check_idle("busy_after_done", 0);
        check_pops("single_pop", 0, p0 + 1);
    endtask

    task automatic test_parity;
        int p, ts, te;
        for (int d = 0; d < 2; d++) begin
            p = pops[d];
            push(d, 8'hA3);
            check_frame(d, 8'hA3, ts, te);
            @(negedge clk);
            check_pops("parity_pop", d, p + 1);
        end
    endtask

    task automatic test_back_to_back;
        int p, ts1, te1, ts2, te2;
        p = pops[1];
        push(1, 8'h00);
        push(1, 8'hFF);
        check_frame(1, 8'h00, ts1, te1);
        check_frame(1, 8'hFF, ts2, te2);
        vectors++;
        if (ts2 - te1 != 4) begin
            $display("FAIL b2b_gap: next start %0d clocks after last stop clock, required 4", ts2 - te1);
            miscompares++;
        end
        repeat (10) @(negedge clk);
        check_pops("b2b_pops", 1, p + 2);
    endtask

    task automatic test_random_stream;
        logic [7:0] bytes [4];
        int p, ts, te, prev_te;
        p = pops[0];
        prev_te = 0;
        for (int i = 0; i < 4; i++) begin
            bytes[i] = 8'($urandom);
            push(0, bytes[i]);
        end
        for (int i = 0; i < 4; i++) begin
            check_frame(0, bytes[i], ts, te);
            if (i > 0) begin
                vectors++;
                if (ts - prev_te != 4) begin
                    $display("FAIL stream_gap frame %0d: gap %0d, required 4", i, ts - prev_te);
                    miscompares++;
                end
            end
            prev_te = te;
        end
        repeat (10) @(negedge clk);
        check_pops("stream_pops", 0, p + 4);
    endtask

    task automatic test_reset_mid_frame;
        int n, p, ts, te;
        logic [7:0] b;
        push(0, 8'h0F);
        n = 0;
        @(negedge clk);
        while (tx[0] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        vectors++;
        if (tx[0] !== 1'b0) begin
            $display("FAIL pre_reset_bit4: tx=%b, required 0", tx[0]);
            miscompares++;
        end
        rst_n = 1'b0;
        #1;
        check_idle("async_reset", 0);
        repeat (3) @(negedge clk);
        check_idle("held_reset", 0);
        b = 8'($urandom);
        push(0, b);
        @(negedge clk);
        p = pops[0];
        rst_n = 1'b1;
        check_frame(0, b, ts, te);
        @(negedge clk);
        check_pops("post_reset_pop", 0, p + 1);
    endtask

    task automatic test_empty_toggle;
        int p, ts, te;
        logic [7:0] b;
        b = 8'($urandom);
        p = pops[0];
        push(0, b);
        fork
            check_frame(0, b, ts, te);
            begin
                repeat (6 * CPB) @(negedge clk);
                glitch[0] = 1'b1;
                @(negedge clk);
                glitch[0] = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check_pops("glitch_no_pop", 0, p + 1);
        check_idle("glitch_idle", 0);
    endtask

    initial begin
        rst_n = 1'b0;
        glitch[0] = 1'b0;
        glitch[1] = 1'b0;
        emp_q[0] = 1'b1;
        emp_q[1] = 1'b1;
        fifo_data[0] = '0;
        fifo_data[1] = '0;
        pops[0] = 0;
        pops[1] = 0;
        cyc = 0;
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_random_stream();
        test_reset_mid_frame();
        test_empty_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
